// File: rtl/inst_prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch_pkg
//  Description : Shared constants, counter-width helper and queue entry
//                layout for the LC3 prefetching instruction-fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_prefetch_pkg;

    // LC3 user programs conventionally start at x3000
    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

    // Counters must hold the value DEPTH itself, hence one bit over the index width
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Default-width layout of one queue entry: address of the word, then the word
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } lc3_entry_t;

endpackage : inst_prefetch_pkg
`default_nettype wire

// File: rtl/inst_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous in-order queue with push, pop, flush and an
//                occupancy output. Storage is cleared on reset so the head
//                reads zero until the first push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: flush empties the queue; otherwise push/pop move the pointers
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch
//  Description : Prefetching LC3 instruction-fetch unit. A fetch-PC counter
//                issues credit-limited requests, responses fill an in-order
//                queue, and decode drains it via valid/ready. Redirects flush
//                the queue and drop every response still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LC3_RESET_PC)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_GNT,
    input  logic              MEM_VALID,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              IR_VALID,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    input  logic              IR_READY
);

    localparam int CNT_W   = cnt_width(DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;

    logic [CNT_W-1:0]   w_occupancy;
    logic [CNT_W:0]     w_inflight;
    logic               w_credit;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;

    // Queue slots already spoken for: filled entries plus responses on their way
    assign w_inflight = {1'b0, w_occupancy} + {1'b0, outstanding_q};
    assign w_credit   = w_inflight < (CNT_W + 1)'(DEPTH);

    assign MEM_REQ  = !RST && !REDIRECT && w_credit;
    assign MEM_ADDR = fetch_pc_q;
    assign w_issue  = MEM_REQ && MEM_GNT;

    assign IR_VALID = (w_occupancy != '0) && !REDIRECT;
    assign w_pop    = IR_VALID && IR_READY;

    // Next-state for fetch/response PCs and the in-flight bookkeeping; redirect wins
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        w_push        = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(w_issue) - CNT_W'(MEM_VALID);
        if (REDIRECT) begin
            fetch_pc_d = REDIRECT_PC;
            resp_pc_d  = REDIRECT_PC;
            // Everything still in flight belongs to the abandoned stream
            discard_d  = outstanding_d;
        end else begin
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            if (MEM_VALID) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    w_push    = 1'b1;
                    resp_pc_d = resp_pc_q + 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (w_push),
        .push_data ({resp_pc_q, MEM_DATA}),
        .pop       (w_pop),
        .flush     (REDIRECT),
        .head_data (w_head),
        .count     (w_occupancy)
    );

    assign IR_PC = w_head[ENTRY_W-1:DATA_W];
    assign IR    = w_head[DATA_W-1:0];

endmodule : inst_prefetch
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_prefetch
//  Description : Self-checking bench for inst_prefetch. An in-order memory
//                with programmable latency answers fetches; a stream-level
//                model (epoch-tagged in-flight list, expected next PC) gives
//                the required request, valid and instruction values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REDIRECT;
    logic [15:0] REDIRECT_PC;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_GNT;
    logic        MEM_VALID;
    logic [15:0] MEM_DATA;
    logic        IR_VALID;
    logic [15:0] IR;
    logic [15:0] IR_PC;
    logic        IR_READY;

    inst_prefetch #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h3000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .MEM_REQ     (MEM_REQ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_GNT     (MEM_GNT),
        .MEM_VALID   (MEM_VALID),
        .MEM_DATA    (MEM_DATA),
        .IR_VALID    (IR_VALID),
        .IR          (IR),
        .IR_PC       (IR_PC),
        .IR_READY    (IR_READY)
    );

    always #5 CLK = ~CLK;

    // In-flight fetch: address, stream epoch it belongs to, cycle it returns
    typedef struct {
        logic [15:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          epoch;
    int          occ;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
    int          cyc;
    int          last_due;
    int          k;
    int          grants;
    int          n_tests;
    int          n_fail;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, advance model
    task automatic cycle(input logic redir, input logic [15:0] rpc,
                         input logic rdy, input logic gnt);
        logic  exp_req;
        logic  exp_vld;
        pend_t e;
        int    d;
        @(negedge CLK);
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        IR_READY    = rdy;
        MEM_GNT     = gnt;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            MEM_VALID = 1'b1;
            MEM_DATA  = mem_word(pend[0].addr);
        end else begin
            MEM_VALID = 1'b0;
            MEM_DATA  = 16'($urandom);
        end
        #1;
        exp_req = !redir && ((occ + pend.size()) < DEPTH);
        exp_vld = (occ != 0) && !redir;
        check("mem_req", 32'(MEM_REQ), 32'(exp_req));
        check("ir_valid", 32'(IR_VALID), 32'(exp_vld));
        if (exp_vld) begin
            check("ir_pc", 32'(IR_PC), 32'(exp_pc));
            check("ir", 32'(IR), 32'(mem_word(exp_pc)));
            if (rdy) begin
                occ--;
                exp_pc = exp_pc + 16'd1;
            end
        end
        if (MEM_VALID) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch) occ++;
        end
        if (exp_req && gnt) begin
            check("mem_addr", 32'(MEM_ADDR), 32'(exp_addr));
            d = cyc + k;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: exp_addr, epoch: epoch, due: d});
            exp_addr = exp_addr + 16'd1;
            grants++;
        end
        if (redir) begin
            epoch++;
            occ      = 0;
            exp_pc   = rpc;
            exp_addr = rpc;
        end
        cyc++;
    endtask

    // Assert reset (asynchronously, mid-cycle), check reset values, release it
    task automatic do_reset();
        @(negedge CLK);
        RST         = 1'b1;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        MEM_GNT     = 1'b0;
        MEM_VALID   = 1'b0;
        MEM_DATA    = '0;
        IR_READY    = 1'b0;
        #1;
        check("rst_mem_req", 32'(MEM_REQ), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'h3000);
        check("rst_ir_valid", 32'(IR_VALID), 32'd0);
        check("rst_ir", 32'(IR), 32'd0);
        check("rst_ir_pc", 32'(IR_PC), 32'd0);
        @(negedge CLK);
        #1;
        check("rst_hold_mem_req", 32'(MEM_REQ), 32'd0);
        pend.delete();
        epoch++;
        occ      = 0;
        exp_pc   = 16'h3000;
        exp_addr = 16'h3000;
        cyc      = cyc + 2;
        last_due = cyc;
        RST      = 1'b0;
    endtask

    initial begin
        int  g0;
        int  rp;
        int  gp;
        bit  found;
        RST = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0; MEM_GNT = 1'b0;
        MEM_VALID = 1'b0; MEM_DATA = '0; IR_READY = 1'b0;
        n_tests = 0; n_fail = 0; epoch = 0; occ = 0; cyc = 0; last_due = 0;
        grants = 0; k = 1; exp_pc = 16'h3000; exp_addr = 16'h3000;

        // Streaming at full rate with single-cycle memory latency
        do_reset();
        k = 1;
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Decode stalled: exactly DEPTH grants, then drain and resume
        do_reset();
        g0 = grants;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("stall_grants", 32'(grants - g0), 32'(DEPTH));
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Latency 3, redirect with stale responses in flight
        do_reset();
        k = 3;
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("stale_inflight", 32'(pend.size()), 32'd2);
        cycle(1'b1, 16'h4000, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Redirect landing on a cycle with a response and a ready decode
        do_reset();
        k = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (occ != 0 && pend.size() != 0 && pend[0].due <= cyc) begin
                cycle(1'b1, 16'h5123, 1'b1, 1'b1);
                found = 1'b1;
            end else begin
                cycle(1'b0, '0, 1'b0, 1'b1);
            end
        end
        check("redir_with_valid_reached", 32'(found), 32'd1);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Fetch PC wrapping through FFFF
        k = 1;
        cycle(1'b1, 16'hFFFE, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Reset mid-stream with three queued entries, then restart
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (occ == 3) found = 1'b1;
            else cycle(1'b0, '0, 1'b0, 1'b1);
        end
        check("queue_of_three_reached", 32'(found), 32'd1);
        do_reset();
        k = 1;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Randomised traffic: varying latency, grant/ready rates and redirects
        for (int p = 0; p < 10; p++) begin
            k  = $urandom_range(1, 4);
            rp = $urandom_range(20, 100);
            gp = $urandom_range(20, 100);
            for (int n = 0; n < 300; n++) begin
                logic        rd;
                logic [15:0] tgt;
                rd  = ($urandom_range(0, 99) < 3);
                tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
                cycle(rd, tgt, ($urandom_range(0, 99) < rp), ($urandom_range(0, 99) < gp));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inst_prefetch
`default_nettype wire
